// File: rtl/huffman_bitpacker.sv
// Huffman bit packer: latches a six-entry code table, packs symbol codes MSB-first into bytes.
// Latency: accepted symbol -> byte_valid one cycle later; table latched -> sym_ready next cycle.
// Backpressure: sym_ready drops while more than 8 bits are pending; byte_data holds until byte_ready. Optional: HUFFMAN_BITPACKER_ERR_EN.
module huffman_bitpacker #(
    parameter int ACC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  HC1,
    input  logic [7:0]  HC2,
    input  logic [7:0]  HC3,
    input  logic [7:0]  HC4,
    input  logic [7:0]  HC5,
    input  logic [7:0]  HC6,
    input  logic [7:0]  M1,
    input  logic [7:0]  M2,
    input  logic [7:0]  M3,
    input  logic [7:0]  M4,
    input  logic [7:0]  M5,
    input  logic [7:0]  M6,
    input  logic        sym_valid,
    input  logic [7:0]  sym_data,
    input  logic        sym_last,
    output logic        sym_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    input  logic        byte_ready,
    output logic        done,
    output logic        err,
    output logic [15:0] bit_total
);

    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       hc_tab  [1:6];
    logic [3:0]       len_tab [1:6];
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] bit_cnt;

    logic [7:0]       sel_code;
    logic [3:0]       sel_len;
    logic             sym_ok;
    logic             accept;
    logic             append;
    logic             pop;
    logic [CNT_W-1:0] app_len;
    logic [CNT_W-1:0] pop_len;
    logic [ACC_W-1:0] aligned;

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

    // Table lookup; out-of-range symbols and zero-length entries read as length 0.
    always_comb begin
        sel_len  = '0;
        sel_code = '0;
        case (sym_data)
            8'd1: begin sel_len = len_tab[1]; sel_code = hc_tab[1]; end
            8'd2: begin sel_len = len_tab[2]; sel_code = hc_tab[2]; end
            8'd3: begin sel_len = len_tab[3]; sel_code = hc_tab[3]; end
            8'd4: begin sel_len = len_tab[4]; sel_code = hc_tab[4]; end
            8'd5: begin sel_len = len_tab[5]; sel_code = hc_tab[5]; end
            8'd6: begin sel_len = len_tab[6]; sel_code = hc_tab[6]; end
            default: begin sel_len = '0; sel_code = '0; end
        endcase
    end

    assign sym_ok  = (sel_len != 4'd0);
    assign accept  = sym_valid && sym_ready;
    assign append  = accept && sym_ok;
    assign pop     = byte_valid && byte_ready;
    assign app_len = append ? CNT_W'(sel_len) : '0;
    assign pop_len = pop ? CNT_W'(8) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (code_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && sym_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (bit_cnt == '0) begin
                    state_nxt = S_DONE;
                end else if (pop && byte_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

    always_comb begin
        sym_ready  = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        done       = 1'b0;
        case (state)
            S_RUN: begin
                sym_ready  = (bit_cnt <= CNT_W'(8));
                byte_valid = (bit_cnt >= CNT_W'(8));
            end
            S_FLUSH: begin
                byte_valid = (bit_cnt != '0);
                byte_last  = (bit_cnt != '0) && (bit_cnt <= CNT_W'(8));
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                sym_ready = 1'b0;
            end
        endcase
    end

    // Oldest pending bit lands in bit7; a short tail is left-justified with zero padding.
    always_comb begin
        if (bit_cnt >= CNT_W'(8)) begin
            aligned = acc >> (bit_cnt - CNT_W'(8));
        end else begin
            aligned = acc << (CNT_W'(8) - bit_cnt);
        end
        byte_data = byte_valid ? aligned[7:0] : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 6; i++) begin
                hc_tab[i]  <= '0;
                len_tab[i] <= '0;
            end
        end else if (state == S_WAIT && code_valid) begin
            hc_tab[1]  <= HC1 & M1;
            hc_tab[2]  <= HC2 & M2;
            hc_tab[3]  <= HC3 & M3;
            hc_tab[4]  <= HC4 & M4;
            hc_tab[5]  <= HC5 & M5;
            hc_tab[6]  <= HC6 & M6;
            len_tab[1] <= popcount8(M1);
            len_tab[2] <= popcount8(M2);
            len_tab[3] <= popcount8(M3);
            len_tab[4] <= popcount8(M4);
            len_tab[5] <= popcount8(M5);
            len_tab[6] <= popcount8(M6);
        end
    end

    // Bits above bit_cnt are stale; the shift may push them out without loss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            bit_cnt   <= '0;
            bit_total <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (append) begin
                        acc       <= (acc << sel_len) | ACC_W'(sel_code);
                        bit_total <= bit_total + 16'(sel_len);
                    end
                    bit_cnt <= bit_cnt + app_len - pop_len;
                end
                S_FLUSH: begin
                    if (pop) begin
                        bit_cnt <= byte_last ? '0 : bit_cnt - CNT_W'(8);
                    end
                end
                default: begin
                    bit_cnt <= bit_cnt;
                end
            endcase
        end
    end

`ifdef HUFFMAN_BITPACKER_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && !sym_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_bitpacker.sv
// Testbench for huffman_bitpacker: random and directed streams scored against a bit-queue packing model.
module tb_huffman_bitpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0]  M1, M2, M3, M4, M5, M6;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_last;
    logic        sym_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        done;
    logic        err;
    logic [15:0] bit_total;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;

    logic [7:0] tc [1:6];
    int         tl [1:6];
    logic [7:0] exp_data [$];
    bit         exp_last [$];

`ifdef HUFFMAN_BITPACKER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    huffman_bitpacker #(.ACC_W(16)) dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .done(done), .err(err), .bit_total(bit_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [7:0] mk(input int l);
        return 8'((32'd1 << l) - 1);
    endfunction

    // Reference: concatenate code strings root-edge first, cut into bytes, zero-pad the tail.
    task automatic model(input int syms[$], output int nbits, output bit bad);
        bit q[$];
        logic [7:0] by;
        int s;
        nbits = 0;
        bad = 1'b0;
        foreach (syms[i]) begin
            s = syms[i];
            if (s >= 1 && s <= 6 && tl[s] > 0) begin
                for (int b = tl[s] - 1; b >= 0; b--) begin
                    q.push_back(tc[s][b]);
                    nbits++;
                end
            end else begin
                bad = 1'b1;
            end
        end
        while (q.size() > 0) begin
            by = 8'h00;
            for (int i = 0; i < 8; i++) begin
                by = {by[6:0], (q.size() > 0) ? q.pop_front() : 1'b0};
            end
            exp_data.push_back(by);
            exp_last.push_back(q.size() == 0);
        end
    endtask

    initial begin
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: byte_ready = 1'b0;
                1: byte_ready = 1'b1;
                default: byte_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: a transfer seen at the negedge completes on the following posedge.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_dat;
        logic [7:0] d;
        bit         l;
        prev_stall = 1'b0;
        prev_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold_data", {byte_valid, byte_data}, {1'b1, prev_dat});
                if (byte_valid && byte_ready) begin
                    if (exp_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h with no byte expected", byte_data);
                    end else begin
                        d = exp_data.pop_front();
                        l = exp_last.pop_front();
                        chk("byte_data", byte_data, d);
                        chk("byte_last", byte_last, l);
                    end
                end
                prev_stall = byte_valid && !byte_ready;
                prev_dat = byte_data;
            end
        end
    end

    task automatic apply_table();
        HC1 = tc[1]; HC2 = tc[2]; HC3 = tc[3]; HC4 = tc[4]; HC5 = tc[5]; HC6 = tc[6];
        M1 = mk(tl[1]); M2 = mk(tl[2]); M3 = mk(tl[3]);
        M4 = mk(tl[4]); M5 = mk(tl[5]); M6 = mk(tl[6]);
    endtask

    // Holds code_valid a second cycle with a different table, which must be ignored.
    task automatic load_table();
        apply_table();
        code_valid = 1'b1;
        @(posedge clk); #1;
        HC1 = ~tc[1]; HC2 = ~tc[2]; HC3 = ~tc[3]; HC4 = ~tc[4]; HC5 = ~tc[5]; HC6 = ~tc[6];
        M1 = 8'hFF; M2 = 8'hFF; M3 = 8'hFF; M4 = 8'hFF; M5 = 8'hFF; M6 = 8'hFF;
        @(negedge clk);
        chk("ready_after_table", sym_ready, 1);
        @(posedge clk); #1;
        code_valid = 1'b0;
    endtask

    task automatic reset_pulse(input bit check_zero);
        reset = 1'b1;
        sym_valid = 1'b0;
        sym_last = 1'b0;
        code_valid = 1'b0;
        #1;
        if (check_zero) begin
            chk("reset_flags", {sym_ready, byte_valid, byte_last, done, err}, 0);
            chk("reset_byte_data", byte_data, 0);
            chk("reset_bit_total", bit_total, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic send_sym(input int s, input bit last);
        bit got;
        got = 1'b0;
        sym_valid = 1'b1;
        sym_data = 8'(s);
        sym_last = last;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            got = sym_ready;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        sym_last = 1'b0;
        if (!got) fail("sym_accept");
    endtask

    task automatic finish_stream(input int nbits, input bit bad);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done", done, 1);
        chk("done_idle", {byte_valid, sym_ready}, 0);
        chk("bit_total", bit_total, nbits);
        chk("err", err, ERR_EN && bad);
        chk("bytes_drained", exp_data.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input int syms[$]);
        int nbits;
        bit bad;
        model(syms, nbits, bad);
        foreach (syms[i]) send_sym(syms[i], i == syms.size() - 1);
        finish_stream(nbits, bad);
    endtask

    initial begin
        int q[$];
        int nb;
        bit bad;
        int n;
        int s;
        reset = 1'b0;
        code_valid = 1'b0;
        sym_valid = 1'b0;
        sym_data = 8'h00;
        sym_last = 1'b0;
        tc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
        tl = '{1, 2, 3, 4, 5, 5};
        apply_table();
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset_pulse(1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("wait_table_ready", sym_ready, 0);
        end
        @(posedge clk); #1;

        rdy_mode = 1;
        load_table();
        q = '{2, 2, 2, 2};
        run_stream(q);

        reset_pulse(1'b0); load_table();
        q = '{1, 3};
        run_stream(q);

        reset_pulse(1'b0); load_table();
        q = '{6, 6};
        run_stream(q);

        rdy_mode = 0;
        reset_pulse(1'b0); load_table();
        q = '{6, 6, 6, 6};
        model(q, nb, bad);
        send_sym(6, 0);
        send_sym(6, 0);
        sym_valid = 1'b1; sym_data = 8'd6; sym_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_sym_ready", sym_ready, 0);
            chk("bp_byte", {byte_valid, byte_data}, {1'b1, 8'hFF});
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        send_sym(6, 0);
        send_sym(6, 1);
        finish_stream(nb, bad);

        reset_pulse(1'b0); load_table();
        q = '{7, 2};
        run_stream(q);

        reset_pulse(1'b0); load_table();
        q = '{1, 3, 9};
        run_stream(q);

        rdy_mode = 0;
        reset_pulse(1'b0); load_table();
        send_sym(6, 0);
        send_sym(2, 0);
        send_sym(6, 0);
        @(negedge clk);
        chk("pre_reset_valid", byte_valid, 1);
        @(posedge clk); #1;
        reset_pulse(1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_ready", sym_ready, 0);
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        load_table();
        q = '{2, 2, 2, 2};
        run_stream(q);

        for (int it = 0; it < 25; it++) begin
            for (int i = 1; i <= 6; i++) begin
                tl[i] = $urandom_range(0, 8);
                tc[i] = 8'($urandom) & mk(tl[i]);
            end
            if (tl[1] == 0 && tl[2] == 0 && tl[3] == 0 && tl[4] == 0 && tl[5] == 0 && tl[6] == 0)
                tl[1] = 1;
            n = $urandom_range(1, 24);
            q.delete();
            for (int i = 0; i < n - 1; i++) q.push_back($urandom_range(0, 8));
            do s = $urandom_range(1, 6); while (tl[s] == 0);
            q.push_back(s);
            rdy_mode = 2;
            reset_pulse(1'b0);
            load_table();
            run_stream(q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/huffman_bitpacker.md
Name: huffman_bitpacker

Overview:
- Downstream stage of the Huffman table builder.
- Latches the six-entry code table (HC1..HC6 codes, M1..M6 masks) when code_valid rises.
- Encodes a replayed gray-level symbol stream (values 1..6) into a packed, MSB-first byte stream.
- Uses valid/ready handshakes on both the symbol input and the byte output; flushes a zero-padded final byte on stream end.

Parameters:
ACC_W, 16, bit-accumulator width; must be >= 16 (max 8 pending bits + 8-bit code).

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
code_valid  input  1  code table valid (level; first high sample latched)
HC1..HC6  input  8 each  Huffman code per symbol, bit0 = leaf-side edge
M1..M6  input  8 each  code mask per symbol, contiguous ones from bit0; popcount = code length
sym_valid  input  1  symbol present
sym_data  input  8  symbol value
sym_last  input  1  final symbol of stream (qualified by sym_valid)
sym_ready  output  1  block accepts symbol
byte_valid  output  1  packed byte present
byte_data  output  8  packed byte, first-emitted code bit in bit7
byte_last  output  1  final byte of stream
byte_ready  input  1  downstream accepts byte
done  output  1  stream fully emitted; sticky
err  output  1  sticky invalid-symbol flag
bit_total  output  16  count of code bits packed (excludes padding); wraps mod 2^16

Behaviour:
- Reset (async): state WAIT_TABLE; all outputs 0; bit_cnt=0; acc=0; len table cleared.
- States: WAIT_TABLE -> RUN -> FLUSH -> DONE.
- WAIT_TABLE:
  - sym_ready=0.
  - On the first clk edge with code_valid=1: register HCi, and leni = popcount(Mi) (0..8). Next state RUN.
  - Further code_valid activity ignored until reset.
- RUN:
  - sym_ready = (bit_cnt <= 8).
  - Accept on sym_valid && sym_ready. For symbol s in 1..6 with len>0:
    - acc <= (acc << len) | HC[len-1:0]
    - bit_cnt += len
    - bit_total += len
  - Bits are emitted code-MSB first: HC bit len-1 (root edge) first, bit0 last.
  - Symbol not in 1..6, or len=0: no bits appended; err <= 1 (see optional feature). sym_last on such a symbol is still honoured.
  - byte_valid = (bit_cnt >= 8); byte_data = acc[bit_cnt-1 -: 8]; byte_last=0.
  - Pop on byte_valid && byte_ready: bit_cnt -= 8.
  - Simultaneous accept and pop in one cycle: bit_cnt <= bit_cnt + len - 8.
  - byte_data stays stable while byte_valid && !byte_ready. Appends only add low bits, so the top bits are unchanged.
  - Accepted symbol with sym_last=1: next state FLUSH.
- FLUSH:
  - sym_ready=0.
  - bit_cnt >= 8: emit the full byte as in RUN; byte_last = (bit_cnt == 8).
  - bit_cnt in 1..7: byte_valid=1; byte_data = acc[bit_cnt-1:0] << (8-bit_cnt) (zero pad in the LSBs); byte_last=1.
  - Handshake of the byte with byte_last=1: bit_cnt <= 0; next state DONE.
  - bit_cnt=0 on entry (empty stream, or only invalid symbols): go directly to DONE; no byte emitted.
- DONE:
  - done=1; sym_ready=0; byte_valid=0.
  - Holds until reset.
- Latency:
  - Symbol accepted at edge N -> byte_valid visible after edge N (registered path, one cycle).
  - Table latched at edge T -> sym_ready may assert in the cycle after T.
- Throughput: one symbol per cycle while the accumulator has space and bytes are drained each cycle.
- Reset mid-operation: accumulator contents discarded; state returns to WAIT_TABLE; table must be re-presented.

Optional Feature:
HUFFMAN_BITPACKER_ERR_EN
- Defined: invalid symbols (outside 1..6, or len=0) set err (sticky) and are dropped.
- Undefined: err tied to 0; invalid symbols are still dropped silently; no detection logic.

Test Plan:
- Common table for all scenarios:
  - HC1=0x00 M1=0x01 ("0")
  - HC2=0x02 M2=0x03 ("10")
  - HC3=0x06 M3=0x07 ("110")
  - HC4=0x0E M4=0x0F
  - HC5=0x1E M5=0x1F
  - HC6=0x1F M6=0x1F ("11111")
1. Symbols 2,2,2,2 (last on 4th), byte_ready=1 -> one byte 0xAA, byte_last=1; done=1; bit_total=8.
2. Symbols 1,3 (last) -> bits "0110" -> single byte 0x60, byte_last=1; bit_total=4.
3. Symbols 6,6 (last) -> 0xFF (byte_last=0), then 0xC0 (byte_last=1); bit_total=10.
4. Backpressure: byte_ready=0, offer 6,6,6,6:
   - After two accepts, bit_cnt=10 and sym_ready=0; byte_data holds 0xFF stable.
   - Release byte_ready -> bytes 0xFF, 0xFF, 0xF0 (last); no symbol lost.
5. Error path (ERR_EN defined): symbols 7, 2 (last) -> err=1; output byte 0x80, byte_last=1; bit_total=2.
6. Reset asserted mid-stream after 3 symbols -> all outputs 0, state WAIT_TABLE, sym_ready=0 until code_valid is re-asserted.
